// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
//   - assembly FSM state encoding
//   - default reset and interrupt vectors
package fetch_pkg;

   localparam logic [0:0] S_OP  = 1'b0;   // expecting an opcode word
   localparam logic [0:0] S_IMM = 1'b1;   // opcode held, expecting its immediate

   localparam logic [31:0] RESET_VEC_DEF = 32'h20;
   localparam logic [31:0] INT_VEC_DEF   = 32'h0;

endpackage : fetch_pkg

// File: rtl/fetch_unit_pc_select.sv
// pc_select: combinational next-PC priority mux.
// Priority: interrupt > jump > stall (hold) > sequential.
// Ports:
//   i_int, i_jump, i_stall   redirect / hold requests
//   i_jump_target            jump destination
//   i_pc, i_pc_inc           current PC and PC+1
//   o_pc_next_c              selected next PC (combinational)
module pc_select #(
   parameter int unsigned ADDR_W = 32,
   parameter logic [31:0] INT_VEC = 32'h0
) (
   input  logic              i_int,
   input  logic              i_jump,
   input  logic              i_stall,
   input  logic [ADDR_W-1:0] i_jump_target,
   input  logic [ADDR_W-1:0] i_pc,
   input  logic [ADDR_W-1:0] i_pc_inc,
   output logic [ADDR_W-1:0] o_pc_next_c
);

   localparam logic [ADDR_W-1:0] INT_PC = ADDR_W'(INT_VEC);

   always_comb begin
      o_pc_next_c = i_pc_inc;
      if (i_int)        o_pc_next_c = INT_PC;
      else if (i_jump)  o_pc_next_c = i_jump_target;
      else if (i_stall) o_pc_next_c = i_pc;
   end

endmodule : pc_select

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch stage. Owns the PC, reads a combinational
// instruction memory and assembles one- or two-word instructions for decode.
// Ports:
//   clk, rst                   clock, async active-high reset
//   stall, jumpBit, jumpTarget pipeline hold and redirect
//   interruptBit               interrupt pulse; vectors to INT_VEC
//   imemAddr, imemData         instruction memory (address = pc)
//   instrOut, immOut           delivered opcode and immediate (0 if none)
//   validOut                   delivered instruction is real
//   instrPcOut, nextPcOut      opcode address and fall-through PC
//   epcOut                     return PC captured on the last interrupt
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned INSTR_W   = 16,
   parameter logic [31:0] RESET_VEC = RESET_VEC_DEF,
   parameter logic [31:0] INT_VEC   = INT_VEC_DEF,
   parameter int unsigned IMM_BIT   = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               jumpBit,
   input  logic [ADDR_W-1:0]  jumpTarget,
   input  logic               interruptBit,
   output logic [ADDR_W-1:0]  imemAddr,
   input  logic [INSTR_W-1:0] imemData,
   output logic [INSTR_W-1:0] instrOut,
   output logic [INSTR_W-1:0] immOut,
   output logic               validOut,
   output logic [ADDR_W-1:0]  instrPcOut,
   output logic [ADDR_W-1:0]  nextPcOut,
   output logic [ADDR_W-1:0]  epcOut
);

   localparam logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VEC);

   logic [ADDR_W-1:0]  r_pc, r_op_pc, r_ipc, r_npc, r_epc;
   logic [0:0]         r_state;
   logic [INSTR_W-1:0] r_hold, r_instr, r_imm;
   logic               r_valid;

   logic [ADDR_W-1:0]  w_pc_inc, w_pc_next, w_op_pc_nxt, w_ipc_nxt, w_npc_nxt, w_epc_nxt;
   logic [0:0]         w_state_nxt;
   logic [INSTR_W-1:0] w_hold_nxt, w_instr_nxt, w_imm_nxt;
   logic               w_valid_nxt;

   // PC arithmetic wraps modulo 2^ADDR_W
   assign w_pc_inc = r_pc + ADDR_W'(1);

   pc_select #(
      .ADDR_W  (ADDR_W),
      .INT_VEC (INT_VEC)
   ) u_pc_select (
      .i_int         (interruptBit),
      .i_jump        (jumpBit),
      .i_stall       (stall),
      .i_jump_target (jumpTarget),
      .i_pc          (r_pc),
      .i_pc_inc      (w_pc_inc),
      .o_pc_next_c   (w_pc_next)
   );

   // State register plus all output/datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc    <= RESET_PC;
         r_state <= S_OP;
         r_hold  <= '0;
         r_op_pc <= '0;
         r_instr <= '0;
         r_imm   <= '0;
         r_valid <= 1'b0;
         r_ipc   <= '0;
         r_npc   <= '0;
         r_epc   <= '0;
      end else begin
         r_pc    <= w_pc_next;
         r_state <= w_state_nxt;
         r_hold  <= w_hold_nxt;
         r_op_pc <= w_op_pc_nxt;
         r_instr <= w_instr_nxt;
         r_imm   <= w_imm_nxt;
         r_valid <= w_valid_nxt;
         r_ipc   <= w_ipc_nxt;
         r_npc   <= w_npc_nxt;
         r_epc   <= w_epc_nxt;
      end
   end

   // Next-state and next-output logic; everything holds unless overridden
   always_comb begin
      w_state_nxt = r_state;
      w_hold_nxt  = r_hold;
      w_op_pc_nxt = r_op_pc;
      w_instr_nxt = r_instr;
      w_imm_nxt   = r_imm;
      w_valid_nxt = r_valid;
      w_ipc_nxt   = r_ipc;
      w_npc_nxt   = r_npc;
      w_epc_nxt   = r_epc;

      if (interruptBit) begin
         // a half-assembled instruction returns to its opcode word
         w_state_nxt = S_OP;
         w_valid_nxt = 1'b0;
         w_epc_nxt   = (r_state == S_IMM) ? r_op_pc : r_pc;
      end else if (jumpBit) begin
         w_state_nxt = S_OP;
         w_valid_nxt = 1'b0;
      end else if (!stall) begin
         case (r_state)
            S_OP: begin
               if (imemData[IMM_BIT]) begin
                  w_hold_nxt  = imemData;
                  w_op_pc_nxt = r_pc;
                  w_valid_nxt = 1'b0;
                  w_state_nxt = S_IMM;
               end else begin
                  w_instr_nxt = imemData;
                  w_imm_nxt   = '0;
                  w_valid_nxt = 1'b1;
                  w_ipc_nxt   = r_pc;
                  w_npc_nxt   = w_pc_inc;
               end
            end
            default: begin
               w_instr_nxt = r_hold;
               w_imm_nxt   = imemData;
               w_valid_nxt = 1'b1;
               w_ipc_nxt   = r_op_pc;
               w_npc_nxt   = r_op_pc + ADDR_W'(2);
               w_state_nxt = S_OP;
            end
         endcase
      end
   end

   assign imemAddr   = r_pc;
   assign instrOut   = r_instr;
   assign immOut     = r_imm;
   assign validOut   = r_valid;
   assign instrPcOut = r_ipc;
   assign nextPcOut  = r_npc;
   assign epcOut     = r_epc;

endmodule : fetch_unit

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised next-generation instruction fetch stage. Owns the PC, selects the next PC (interrupt vector, jump target, hold, sequential) and drives a combinational-read instruction memory.
- Assembles variable-length instructions: one opcode word, optionally followed by one immediate word. Delivers each complete instruction with its PC and fall-through PC to the decode pipeline register.
- Adds behaviour the previous fetch stage lacked: an explicit two-state assembly FSM, a valid/bubble output, and an exception-return PC capture on interrupt.

Parameters:
- ADDR_W, 32, PC and memory address width.
- INSTR_W, 16, instruction and immediate word width.
- RESET_VEC, 32'h20, PC loaded on reset; truncated to ADDR_W.
- INT_VEC, 32'h0, PC loaded on interrupt; truncated to ADDR_W.
- IMM_BIT, 0, index of the opcode-word bit that marks "immediate word follows" (1 = has immediate).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard stall from the pipeline; holds the stage.
- jumpBit  in  1  redirect request from a taken branch or jump.
- jumpTarget  in  ADDR_W  redirect address.
- interruptBit  in  1  interrupt request; single-cycle pulse.
- imemAddr  out  ADDR_W  instruction memory address; equals pc (combinational).
- imemData  in  INSTR_W  word at imemAddr; valid in the same cycle.
- instrOut  out  INSTR_W  opcode word of the delivered instruction.
- immOut  out  INSTR_W  immediate word, or 0 if the instruction has none.
- validOut  out  1  instrOut/immOut/instrPcOut/nextPcOut hold a real instruction.
- instrPcOut  out  ADDR_W  address of the delivered opcode word.
- nextPcOut  out  ADDR_W  fall-through PC (instrPcOut+1 or +2).
- epcOut  out  ADDR_W  return PC captured on the last interrupt.

Behaviour:
- Reset (asynchronous, immediate):
  - pc=RESET_VEC; state=S_OP.
  - instrOut=0, immOut=0, validOut=0, instrPcOut=0, nextPcOut=0, epcOut=0.
  - Internal opPc and holdInstr cleared.
- Addition: all PC arithmetic is modulo 2^ADDR_W. Incrementing from all-ones wraps to 0 with no error.
- Per-edge priority: interrupt > jump > stall > normal operation.
- Interrupt (interruptBit=1, stall ignored):
  - pc<=INT_VEC; state<=S_OP; validOut<=0.
  - epcOut<=pc if state==S_OP; epcOut<=opPc if state==S_IMM, so a half-assembled instruction is refetched after return.
  - If jumpBit is asserted in the same cycle, the jump is dropped.
- Jump (jumpBit=1, no interrupt, stall ignored):
  - pc<=jumpTarget; state<=S_OP; validOut<=0.
  - Any partial instruction is discarded; epcOut is unchanged.
- Stall (no interrupt, no jump): pc, state, holdInstr, opPc and every output hold their values. validOut keeps its value.
- S_OP, normal operation, with imemData[IMM_BIT]=0:
  - instrOut<=imemData; immOut<=0; validOut<=1.
  - instrPcOut<=pc; nextPcOut<=pc+1; pc<=pc+1; stay in S_OP.
- S_OP, normal operation, with imemData[IMM_BIT]=1:
  - holdInstr<=imemData; opPc<=pc; pc<=pc+1; validOut<=0; state<=S_IMM.
- S_IMM, normal operation:
  - instrOut<=holdInstr; immOut<=imemData; validOut<=1.
  - instrPcOut<=opPc; nextPcOut<=opPc+2; pc<=pc+1; state<=S_OP.
  - The immediate word's IMM_BIT is not interpreted.
- Latency and throughput:
  - Address to delivered instruction is one clock.
  - One-word instructions sustain one per cycle.
  - Two-word instructions take two cycles, with one bubble in between.
- Release of reset: the first fetch is from RESET_VEC on the first rising edge after rst deasserts.
- Reset asserted mid-assembly: the FSM is abandoned and no partial output is produced.

Decomposition:
- Shared package fetch_pkg holds:
  - state encoding S_OP=1'b0, S_IMM=1'b1;
  - default vector constants RESET_VEC_DEF=32'h20 and INT_VEC_DEF=32'h0.
- One natural sub-module, pc_select: the combinational priority mux producing pcNext from interrupt, jump, stall, pc+1. It replaces the previous chain of cascaded 2:1 muxes.
- The FSM and output registers stay in fetch_unit.

Test Plan:
- Reset release, memory[0x20..0x22]={0x0010,0x0020,0x0030} all bit0=0: validOut=1 on three consecutive edges, instrPcOut=0x20,0x21,0x22, nextPcOut=0x21,0x22,0x23.
- Two-word instruction, mem[0x20]=0x0011, mem[0x21]=0xBEEF: edge 1 validOut=0; edge 2 instrOut=0x0011, immOut=0xBEEF, instrPcOut=0x20, nextPcOut=0x22.
- Stall held for 3 cycles while in S_IMM: imemAddr stays 0x21 and outputs are frozen; after release, the instruction completes exactly as in the unstalled case.
- Jump to 0x40 in S_IMM with stall=1: validOut=0, next fetch from 0x40, holdInstr discarded, epcOut unchanged.
- Interrupt and jump together, with state S_IMM and opPc=0x30: pc=0x0, epcOut=0x30, jump ignored.
- ADDR_W=4, pc=0xF, one-word instruction: nextPcOut=0x0, pc wraps to 0x0. Asserting rst mid-cycle forces pc=RESET_VEC[3:0] and validOut=0 immediately, without waiting for a clock edge.
